// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS fetch stage: PC, single-outstanding imem fetch, IF/ID register.
// Optional ALIGN_CHECK_EN adds fetch_err and a sticky ERROR state for misaligned targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             Jump,
    input  logic             JumpReg,
    input  logic             Branch,
    input  logic             BranchNot,
    input  logic             Zero,
    input  logic [31:0]      jr_addr,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [CNT_W-1:0] inst_count
`ifdef ALIGN_CHECK_EN
    ,
    output logic             fetch_err
`endif
);

    localparam logic [1:0] S_FETCH  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
`ifdef ALIGN_CHECK_EN
    localparam logic [1:0] S_ERROR  = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      next_pc;
    logic [31:0]      br_off;
    logic             take_branch;

    assign pc_plus4    = pc_q + 32'd4;
    assign br_off      = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign take_branch = (Branch & Zero) | (BranchNot & ~Zero);

    // Priority order resolves conflicting decoder outputs.
    always_comb begin
        next_pc = pc_plus4;
        if (JumpReg) begin
            next_pc = jr_addr;
        end else if (Jump) begin
            next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
        end else if (take_branch) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    pc_d    = fetch_pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!stall) begin
                    fetch_pc_d = next_pc;
                    cnt_d      = cnt_q + CNT_W'(1);
                    state_d    = S_FETCH;
`ifdef ALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = S_ERROR;
                    end
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            instr_q    <= 32'h0;
            pc_q       <= RESET_PC;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = fetch_pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_DECODE);
    assign pc          = pc_q;
    assign inst_count  = cnt_q;
`ifdef ALIGN_CHECK_EN
    assign fetch_err   = (state_q == S_ERROR);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        Jump = 1'b0, JumpReg = 1'b0, Branch = 1'b0, BranchNot = 1'b0, Zero = 1'b0;
    logic [31:0] jr_addr = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst_count;
`ifdef ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] exp_count = 32'h0;

    localparam logic [31:0] W_BEQ = 32'h1000_FFFC;
    localparam logic [31:0] W_BNE = 32'h1400_FFFC;
    localparam logic [31:0] W_J   = 32'h0800_0040;
    localparam logic [31:0] W_JR  = 32'h03E0_0008;
    localparam logic [31:0] W_ADD = 32'h2008_0005;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .Jump(Jump), .JumpReg(JumpReg), .Branch(Branch), .BranchNot(BranchNot), .Zero(Zero),
        .jr_addr(jr_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .inst_count(inst_count)
`ifdef ALIGN_CHECK_EN
        , .fetch_err(fetch_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_count = 32'h0;
    endtask

    // At a negedge in FETCH: check the request, return the word immediately.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== a || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h valid=%b, required req=1 addr=%h valid=0",
                     imem_req, imem_addr, instr_valid, a);
        end
        imem_ready = 1'b1;
        imem_rdata = w;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    // ctl = {JumpReg, Jump, Branch, BranchNot, Zero}
    task automatic do_consume(input logic [4:0] ctl, input logic [31:0] jra,
                              input logic [31:0] epc, input logic [31:0] ein);
        checks++;
        if (instr_valid !== 1'b1 || pc !== epc || instr !== ein || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL decode_hold: valid=%b pc=%h instr=%h req=%b, required valid=1 pc=%h instr=%h req=0",
                     instr_valid, pc, instr, imem_req, epc, ein);
        end
        {JumpReg, Jump, Branch, BranchNot, Zero} = ctl;
        jr_addr = jra;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        {JumpReg, Jump, Branch, BranchNot, Zero} = 5'b0;
        exp_count = exp_count + 32'd1;
        checks++;
        if (inst_count !== exp_count || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL retire: count=%0d valid=%b, required count=%0d valid=0",
                     inst_count, instr_valid, exp_count);
        end
    endtask

    task automatic jump_to(input logic [31:0] cur, input logic [31:0] target);
        do_fetch(cur, W_JR);
        do_consume(5'b10000, target, cur, W_JR);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (instr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0 || inst_count !== 32'h0 ||
            imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset_state: instr=%h valid=%b pc=%h cnt=%0d req=%b addr=%h p4=%h, required 0,0,0,0,1,0,4",
                     instr, instr_valid, pc, inst_count, imem_req, imem_addr, pc_plus4);
        end
`ifdef ALIGN_CHECK_EN
        checks++;
        if (fetch_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_fetch_err: got %b, required 0", fetch_err);
        end
`endif
    endtask

    task automatic test_sequential();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'(i * 4), W_ADD);
            do_consume(5'b0, 32'h0, 32'(i * 4), W_ADD);
        end
        checks++;
        if (inst_count !== 32'd3 || (cyc - t0) != 6 || imem_addr !== 32'hC) begin
            errors++;
            $display("FAIL sequential: count=%0d cycles=%0d addr=%h, required count=3 cycles=6 addr=0000000c",
                     inst_count, cyc - t0, imem_addr);
        end
    endtask

    task automatic test_branch();
        jump_to(32'hC, 32'h10);
        do_fetch(32'h10, W_BEQ);
        do_consume(5'b00101, 32'h0, 32'h10, W_BEQ);
        jump_to(32'h4, 32'h10);
        do_fetch(32'h10, W_BEQ);
        do_consume(5'b00100, 32'h0, 32'h10, W_BEQ);
        jump_to(32'h14, 32'h10);
        do_fetch(32'h10, W_BNE);
        do_consume(5'b00010, 32'h0, 32'h10, W_BNE);
        checks++;
        if (imem_addr !== 32'h4) begin
            errors++;
            $display("FAIL bne_target: addr=%h, required 00000004", imem_addr);
        end
    endtask

    task automatic test_jump();
        jump_to(32'h4, 32'h3000_0000);
        do_fetch(32'h3000_0000, W_J);
        checks++;
        if (pc_plus4 !== 32'h3000_0004) begin
            errors++;
            $display("FAIL link_value: pc_plus4=%h, required 30000004", pc_plus4);
        end
        do_consume(5'b01000, 32'h0, 32'h3000_0000, W_J);
        do_fetch(32'h3000_0100, W_JR);
        do_consume(5'b11000, 32'h200, 32'h3000_0100, W_JR);
        checks++;
        if (imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL jr_priority: addr=%h, required 00000200", imem_addr);
        end
    endtask

    task automatic test_wrap();
        jump_to(32'h200, 32'hFFFF_FFFC);
        do_fetch(32'hFFFF_FFFC, W_ADD);
        checks++;
        if (pc_plus4 !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: pc_plus4=%h, required 00000000", pc_plus4);
        end
        do_consume(5'b0, 32'h0, 32'hFFFF_FFFC, W_ADD);
    endtask

    task automatic test_wait_stall();
        int t0;
        t0 = cyc;
        imem_ready = 1'b0;
        stall = 1'b1;
        Jump = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
                errors++;
                $display("FAIL mem_wait[%0d]: req=%b addr=%h valid=%b, required 1,00000000,0",
                         i, imem_req, imem_addr, instr_valid);
            end
            @(posedge clk);
            @(negedge clk);
        end
        Jump = 1'b0;
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL mem_wait_last: addr=%h, required 00000000", imem_addr);
        end
        imem_ready = 1'b1;
        imem_rdata = W_ADD;
        @(posedge clk);
        @(negedge clk);
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr !== W_ADD || pc !== 32'h0 ||
                inst_count !== exp_count || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h cnt=%0d req=%b, required 1,%h,0,%0d,0",
                         i, instr_valid, instr, pc, inst_count, imem_req, W_ADD, exp_count);
            end
            JumpReg = 1'b1;
            jr_addr = 32'h1234;
            @(posedge clk);
            @(negedge clk);
        end
        JumpReg = 1'b0;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_count = exp_count + 32'd1;
        checks++;
        if (inst_count !== exp_count || (cyc - t0) != 7 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_retire: cnt=%0d cycles=%0d addr=%h req=%b, required cnt=%0d cycles=7 addr=00000004 req=1",
                     inst_count, cyc - t0, imem_addr, imem_req, exp_count);
        end
    endtask

    task automatic test_reset_mid();
        jump_to(32'h4, 32'h40);
        imem_ready = 1'b0;
        apply_reset();
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0 || inst_count !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_fetch: addr=%h req=%b valid=%b cnt=%0d, required 0,1,0,0",
                     imem_addr, imem_req, instr_valid, inst_count);
        end
        do_fetch(32'h0, W_ADD);
        do_consume(5'b0, 32'h0, 32'h0, W_ADD);
        do_fetch(32'h4, W_ADD);
        apply_reset();
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1 || instr_valid !== 1'b0 ||
            inst_count !== 32'h0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL rst_in_decode: addr=%h req=%b valid=%b cnt=%0d instr=%h, required 0,1,0,0,0",
                     imem_addr, imem_req, instr_valid, inst_count, instr);
        end
    endtask

    task automatic test_align();
        jump_to(32'h0, 32'h0000_0102);
`ifdef ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || inst_count !== exp_count) begin
                errors++;
                $display("FAIL align_err[%0d]: err=%b req=%b valid=%b cnt=%0d, required 1,0,0,%0d",
                         i, fetch_err, imem_req, instr_valid, inst_count, exp_count);
            end
            imem_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            imem_ready = 1'b0;
        end
        apply_reset();
        checks++;
        if (fetch_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL align_clear: err=%b req=%b addr=%h, required 0,1,00000000",
                     fetch_err, imem_req, imem_addr);
        end
`else
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0102) begin
            errors++;
            $display("FAIL misaligned_issue: req=%b addr=%h, required 1,00000102", imem_req, imem_addr);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_wait_stall();
        test_reset_mid();
        test_align();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
